// File: rtl/em_stage_reg_pkg.sv
// rtl/em_stage_reg_pkg.sv - shared exception codes, overflow classes and PC defaults for the E/M stage
package em_stage_reg_pkg;

    localparam logic [4:0] EXC_NONE = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_OV   = 5'd12;

    localparam logic [1:0] OV_NONE  = 2'b00;
    localparam logic [1:0] OV_ARITH = 2'b01;
    localparam logic [1:0] OV_LOAD  = 2'b10;
    localparam logic [1:0] OV_STORE = 2'b11;

    localparam logic [31:0] DEF_RESET_PC = 32'h0000_3000;
    localparam logic [31:0] DEF_REQ_PC   = 32'h0000_4180;

    // One stage closer to producing the result; a ready value stays ready.
    function automatic logic [1:0] age_tnew(input logic [1:0] tnew);
        return (tnew == 2'd0) ? 2'd0 : tnew - 2'd1;
    endfunction

endpackage

// File: rtl/em_exc_merge.sv
// rtl/em_exc_merge.sv - folds ALU overflow into the precise exception code; EM_ADDR_OV_EN maps address overflow to AdEL/AdES
module em_exc_merge
    import em_stage_reg_pkg::*;
(
    input  logic [4:0] exc_code,
    input  logic       overflow,
    input  logic [1:0] ov_kind,
    output logic [4:0] merged
);

    always_comb begin
        merged = EXC_NONE;
        if (exc_code != EXC_NONE) begin
            merged = exc_code;
        end else if (overflow) begin
            case (ov_kind)
                OV_NONE:  merged = EXC_NONE;
                OV_ARITH: merged = EXC_OV;
`ifdef EM_ADDR_OV_EN
                OV_LOAD:  merged = EXC_ADEL;
                OV_STORE: merged = EXC_ADES;
`else
                // The M-stage address checker owns AdEL/AdES in this build.
                OV_LOAD, OV_STORE: merged = EXC_NONE;
`endif
                default:  merged = EXC_NONE;
            endcase
        end
    end

endmodule

// File: rtl/em_stage_reg.sv
// rtl/em_stage_reg.sv - E/M pipeline register with flush, bubble, hold and exception merge (option macro EM_ADDR_OV_EN)
module em_stage_reg
    import em_stage_reg_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEF_RESET_PC,
    parameter logic [31:0] REQ_PC   = DEF_REQ_PC
)(
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        en,
    input  logic        bubble,
    input  logic [31:0] E_PC,
    input  logic [31:0] E_Instr,
    input  logic [31:0] E_ALUResult,
    input  logic        E_Overflow,
    input  logic [1:0]  E_OvKind,
    input  logic [31:0] E_RtData,
    input  logic [4:0]  E_WA,
    input  logic [1:0]  E_Tnew,
    input  logic [4:0]  E_ExcCode,
    input  logic        E_BD,
    output logic [31:0] M_PC,
    output logic [31:0] M_Instr,
    output logic [31:0] M_ALUResult,
    output logic [31:0] M_RtData,
    output logic [4:0]  M_WA,
    output logic [1:0]  M_Tnew,
    output logic [4:0]  M_ExcCode,
    output logic        M_BD
);

    logic [4:0] exc_merged;

    em_exc_merge u_exc_merge (
        .exc_code (E_ExcCode),
        .overflow (E_Overflow),
        .ov_kind  (E_OvKind),
        .merged   (exc_merged)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            M_PC        <= RESET_PC;
            M_Instr     <= '0;
            M_ALUResult <= '0;
            M_RtData    <= '0;
            M_WA        <= '0;
            M_Tnew      <= '0;
            M_ExcCode   <= EXC_NONE;
            M_BD        <= 1'b0;
        end else if (req) begin
            M_PC        <= REQ_PC;
            M_Instr     <= '0;
            M_ALUResult <= '0;
            M_RtData    <= '0;
            M_WA        <= '0;
            M_Tnew      <= '0;
            M_ExcCode   <= EXC_NONE;
            M_BD        <= 1'b0;
        end else if (bubble) begin
            // PC and BD ride along so CP0 still sees a correct EPC/BD for the nop.
            M_PC        <= E_PC;
            M_Instr     <= '0;
            M_ALUResult <= '0;
            M_RtData    <= '0;
            M_WA        <= '0;
            M_Tnew      <= '0;
            M_ExcCode   <= EXC_NONE;
            M_BD        <= E_BD;
        end else if (en) begin
            M_PC        <= E_PC;
            M_Instr     <= E_Instr;
            M_ALUResult <= E_ALUResult;
            M_RtData    <= E_RtData;
            M_WA        <= E_WA;
            M_Tnew      <= age_tnew(E_Tnew);
            M_ExcCode   <= exc_merged;
            M_BD        <= E_BD;
        end
    end

endmodule

// File: tb/tb_em_stage_reg.sv
// tb/tb_em_stage_reg.sv - randomized and directed checks of em_stage_reg against a behavioural model
module tb_em_stage_reg;

    logic        clk = 1'b0;
    logic        reset, req, en, bubble;
    logic [31:0] E_PC, E_Instr, E_ALUResult, E_RtData;
    logic        E_Overflow, E_BD;
    logic [1:0]  E_OvKind, E_Tnew;
    logic [4:0]  E_WA, E_ExcCode;
    logic [31:0] M_PC, M_Instr, M_ALUResult, M_RtData;
    logic [4:0]  M_WA, M_ExcCode;
    logic [1:0]  M_Tnew;
    logic        M_BD;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    typedef struct {
        logic [31:0] pc, instr, alu, rt;
        logic [4:0]  wa, exc;
        logic [1:0]  tnew;
        logic        bd;
    } mstate_t;

    mstate_t exp_s, saved;

    always #5 clk = ~clk;

    em_stage_reg dut (
        .clk(clk), .reset(reset), .req(req), .en(en), .bubble(bubble),
        .E_PC(E_PC), .E_Instr(E_Instr), .E_ALUResult(E_ALUResult),
        .E_Overflow(E_Overflow), .E_OvKind(E_OvKind), .E_RtData(E_RtData),
        .E_WA(E_WA), .E_Tnew(E_Tnew), .E_ExcCode(E_ExcCode), .E_BD(E_BD),
        .M_PC(M_PC), .M_Instr(M_Instr), .M_ALUResult(M_ALUResult),
        .M_RtData(M_RtData), .M_WA(M_WA), .M_Tnew(M_Tnew),
        .M_ExcCode(M_ExcCode), .M_BD(M_BD)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req_v);
        tests++;
        if (act !== req_v) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req_v, $time);
        end
    endtask

    function automatic mstate_t zero_state(input logic [31:0] pc);
        mstate_t s;
        s.pc = pc; s.instr = 0; s.alu = 0; s.rt = 0;
        s.wa = 0; s.exc = 0; s.tnew = 0; s.bd = 0;
        return s;
    endfunction

    // Exception priority written directly from the rules: earlier code, then overflow class.
    function automatic logic [4:0] model_exc(input logic [4:0] code, input logic ov, input logic [1:0] kind);
        if (code != 0) return code;
        if (!ov) return 0;
        if (kind == 2'd1) return 5'd12;
`ifdef EM_ADDR_OV_EN
        if (kind == 2'd2) return 5'd4;
        if (kind == 2'd3) return 5'd5;
`endif
        return 0;
    endfunction

    function automatic mstate_t next_state(input mstate_t cur);
        mstate_t n;
        n = cur;
        if (req) begin
            n = zero_state(32'h0000_4180);
        end else if (bubble) begin
            n = zero_state(E_PC);
            n.bd = E_BD;
        end else if (en) begin
            n.pc = E_PC; n.instr = E_Instr; n.alu = E_ALUResult; n.rt = E_RtData;
            n.wa = E_WA; n.bd = E_BD;
            n.tnew = (E_Tnew > 0) ? 2'(int'(E_Tnew) - 1) : 2'd0;
            n.exc = model_exc(E_ExcCode, E_Overflow, E_OvKind);
        end
        return n;
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            check("m_pc", M_PC, exp_s.pc);
            check("m_instr", M_Instr, exp_s.instr);
            check("m_alu", M_ALUResult, exp_s.alu);
            check("m_rt", M_RtData, exp_s.rt);
            check("m_wa", 32'(M_WA), 32'(exp_s.wa));
            check("m_tnew", 32'(M_Tnew), 32'(exp_s.tnew));
            check("m_exc", 32'(M_ExcCode), 32'(exp_s.exc));
            check("m_bd", 32'(M_BD), 32'(exp_s.bd));
        end
    end

    task automatic step();
        @(posedge clk);
        if (!reset) exp_s = zero_state(32'h0000_3000);
        else        exp_s = next_state(exp_s);
        @(negedge clk);
        #1;
    endtask

    task automatic randomize_data();
        E_PC        = $urandom;
        E_Instr     = $urandom;
        E_ALUResult = $urandom;
        E_RtData    = $urandom;
        E_Overflow  = 1'($urandom);
        E_OvKind    = 2'($urandom);
        E_WA        = 5'($urandom);
        E_Tnew      = 2'($urandom);
        E_ExcCode   = ($urandom_range(0, 1) == 0) ? 5'd0 : 5'($urandom);
        E_BD        = 1'($urandom);
    endtask

    task automatic load(input logic [31:0] pc, input logic [31:0] alu, input logic ov,
                        input logic [1:0] kind, input logic [4:0] code, input logic [1:0] tnew);
        randomize_data();
        req = 0; bubble = 0; en = 1;
        E_PC = pc; E_ALUResult = alu; E_Overflow = ov; E_OvKind = kind;
        E_ExcCode = code; E_Tnew = tnew;
        step();
    endtask

    initial begin
        reset = 0; req = 0; en = 0; bubble = 0;
        E_PC = 0; E_Instr = 0; E_ALUResult = 0; E_RtData = 0; E_Overflow = 0;
        E_OvKind = 0; E_WA = 0; E_Tnew = 0; E_ExcCode = 0; E_BD = 0;
        exp_s = zero_state(32'h0000_3000);
        chk_en = 1'b1;
        step();
        step();
        check("reset_pc", M_PC, 32'h0000_3000);
        check("reset_instr", M_Instr, 32'h0);

        reset = 1;
        load(32'h3004, 32'h1234, 0, 2'b00, 5'd0, 2'd1);
        check("load_pc", M_PC, 32'h3004);

        load(32'h3008, 32'h8000_0000, 1, 2'b01, 5'd0, 2'd2);
        check("arith_ov_exc", 32'(M_ExcCode), 32'd12);
        check("arith_ov_alu", M_ALUResult, 32'h8000_0000);
        check("tnew_2", 32'(M_Tnew), 32'd1);

        load(32'h300c, 32'h7, 1, 2'b01, 5'd10, 2'd0);
        check("prio_exc", 32'(M_ExcCode), 32'd10);
        check("tnew_0", 32'(M_Tnew), 32'd0);

        load(32'h3010, 32'hffff_fff0, 1, 2'b10, 5'd0, 2'd3);
`ifdef EM_ADDR_OV_EN
        check("load_ov_exc", 32'(M_ExcCode), 32'd4);
`else
        check("load_ov_exc", 32'(M_ExcCode), 32'd0);
`endif

        randomize_data();
        req = 1; bubble = 1; en = 0;
        step();
        check("flush_pc", M_PC, 32'h0000_4180);
        check("flush_alu", M_ALUResult, 32'h0);
        check("flush_bd", 32'(M_BD), 32'd0);

        randomize_data();
        req = 0; bubble = 1; en = 1; E_PC = 32'h3010; E_BD = 1;
        step();
        check("bubble_pc", M_PC, 32'h3010);
        check("bubble_bd", 32'(M_BD), 32'd1);
        check("bubble_instr", M_Instr, 32'h0);
        check("bubble_wa", 32'(M_WA), 32'd0);

        load(32'h3020, 32'hcafe_f00d, 0, 2'b00, 5'd0, 2'd2);
        saved = exp_s;
        for (int i = 0; i < 3; i++) begin
            randomize_data();
            req = 0; bubble = 0; en = 0;
            step();
            check("hold_pc", M_PC, saved.pc);
            check("hold_alu", M_ALUResult, saved.alu);
        end
        load(32'h3024, 32'h55aa_55aa, 0, 2'b00, 5'd0, 2'd1);
        check("resume_pc", M_PC, 32'h3024);

        // Asynchronous reset between edges.
        #2;
        reset = 0;
        exp_s = zero_state(32'h0000_3000);
        #1;
        check("async_pc", M_PC, 32'h0000_3000);
        check("async_alu", M_ALUResult, 32'h0);
        check("async_tnew", 32'(M_Tnew), 32'd0);
        step();
        reset = 1;

        for (int i = 0; i < 400; i++) begin
            randomize_data();
            req    = ($urandom_range(0, 15) == 0);
            bubble = ($urandom_range(0, 7) == 0);
            en     = ($urandom_range(0, 3) != 0);
            step();
        end

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
